// File: rtl/pipelined_carry_select_addsub.sv
// Pipelined carry-select adder/subtractor with valid/ready handshaking.
// The word is cut into BLOCK_SIZE-bit carry-select blocks; BLOCKS_PER_STAGE
// blocks are resolved per register stage, so one result issues per cycle.
// The last stage's registers are the outputs: sum, cout and ovf.
module pipelined_carry_select_addsub #(
    parameter int DATA_WIDTH       = 64,
    parameter int BLOCK_SIZE       = 8,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  ovf
);

    localparam int NUM_BLOCKS = (DATA_WIDTH + BLOCK_SIZE - 1) / BLOCK_SIZE;
    localparam int NUM_STAGES = (NUM_BLOCKS + BLOCKS_PER_STAGE - 1) / BLOCKS_PER_STAGE;
    localparam int IDX_W      = $clog2(DATA_WIDTH);

    // Partial result carried between stages: resolved sum bits, carry out of
    // the highest resolved bit, and carry into the MSB once it is resolved.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] s;
        logic                  c;
        logic                  cm;
    } res_t;

    // Resolve the blocks owned by stage `stg`. Block 0 of the word ripples on
    // the real carry; every other block forms both carry-in hypotheses and
    // selects on the carry arriving from the block below.
    function automatic res_t resolve_stage(
        input int                    stg,
        input logic [DATA_WIDTH-1:0] op_a,
        input logic [DATA_WIDTH-1:0] op_b,
        input res_t                  prev
    );
        res_t             r;
        logic             c_in;
        logic             r0;
        logic             r1;
        logic             m0;
        logic             m1;
        logic             sel;
        logic             s0;
        logic             s1;
        logic             x;
        int               lo;
        logic [IDX_W-1:0] p;
        r    = prev;
        c_in = prev.c;
        for (int j = 0; j < NUM_BLOCKS; j++) begin
            if (j >= stg * BLOCKS_PER_STAGE && j < (stg + 1) * BLOCKS_PER_STAGE) begin
                lo  = j * BLOCK_SIZE;
                sel = (j == 0) ? 1'b0 : c_in;
                r0  = (j == 0) ? c_in : 1'b0;
                r1  = 1'b1;
                m0  = r.cm;
                m1  = r.cm;
                for (int i = 0; i < BLOCK_SIZE; i++) begin
                    if (lo + i < DATA_WIDTH) begin
                        p = IDX_W'(lo + i);
                        if (lo + i == DATA_WIDTH - 1) begin
                            m0 = r0;
                            m1 = r1;
                        end
                        x  = op_a[p] ^ op_b[p];
                        s0 = x ^ r0;
                        s1 = x ^ r1;
                        r0 = (op_a[p] & op_b[p]) | (r0 & x);
                        r1 = (op_a[p] & op_b[p]) | (r1 & x);
                        r.s[p] = sel ? s1 : s0;
                    end
                end
                r.cm = sel ? m1 : m0;
                c_in = sel ? r1 : r0;
            end
        end
        r.c = c_in;
        return r;
    endfunction

    logic [NUM_STAGES-1:0]                 vld_q;
    logic [NUM_STAGES-1:0]                 vld_d;
    logic [NUM_STAGES-1:0]                 src_vld;
    logic [NUM_STAGES-1:0]                 load;
    logic [NUM_STAGES-1:0]                 rdy;
    logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] st_a;
    logic [NUM_STAGES-1:0][DATA_WIDTH-1:0] st_b;
    res_t [NUM_STAGES-1:0]                 st_r;
    logic [DATA_WIDTH-1:0]                 sum_q;
    logic                                  cout_q;
    logic                                  ovf_q;

    // Subtraction is a + ~b + 1, so cin only matters in add mode.
    assign st_a[0] = a;
    assign st_b[0] = sub ? ~b : b;
    assign st_r[0] = {{DATA_WIDTH{1'b0}}, sub | cin, 1'b0};

    // A stage can take new data unless it and every stage above it are full
    // while the output is stalled; this collapses bubbles.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_rdy
        assign rdy[k] = out_ready || !(&vld_q[NUM_STAGES-1:k]);
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = vld_q[NUM_STAGES-1];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Valid shift and load enables; each stage pulls from the one below.
    always_comb begin
        src_vld = NUM_STAGES'({vld_q, in_valid && in_ready});
        load    = rdy & src_vld & {NUM_STAGES{!flush}};
        vld_d   = flush ? '0 : ((rdy & src_vld) | (~rdy & vld_q));
    end

    // Stage valid bits; reset and flush discard all in-flight beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        res_t res_d;

        // Combinational carry-select resolution for this stage's blocks.
        always_comb begin
            res_d = resolve_stage(k, st_a[k], st_b[k], st_r[k]);
        end

        if (k < NUM_STAGES - 1) begin : g_mid
            logic [DATA_WIDTH-1:0] a_q;
            logic [DATA_WIDTH-1:0] b_q;
            res_t                  res_q;

            // Intermediate datapath capture; only valid beats are loaded.
            always_ff @(posedge clk) begin
                if (load[k]) begin
                    a_q   <= st_a[k];
                    b_q   <= st_b[k];
                    res_q <= res_d;
                end
            end

            assign st_a[k+1] = a_q;
            assign st_b[k+1] = b_q;
            assign st_r[k+1] = res_q;
        end else begin : g_last
            // Output registers; held while stalled, cleared by reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (load[k]) begin
                    sum_q  <= res_d.s;
                    cout_q <= res_d.c;
                    ovf_q  <= res_d.c ^ res_d.cm;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_carry_select_addsub.sv
// Bench for pipelined_carry_select_addsub: a 64-bit default instance and a
// 20-bit two-stage instance, each checked against an arithmetic model.
module tb_pipelined_carry_select_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flush;
    logic n_flush;

    logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout, w_ovf;
    logic [63:0] w_a, w_b, w_sum;
    logic        n_in_valid, n_in_ready, n_cin, n_sub, n_out_valid, n_out_ready, n_cout, n_ovf;
    logic [19:0] n_a, n_b, n_sum;

    int total = 0;
    int bad   = 0;

    logic [65:0] q64[$];
    logic [65:0] q20[$];
    logic [63:0] seen64[$];
    logic        hold64 = 1'b0;
    logic        hold20 = 1'b0;
    logic [63:0] hold64_sum;
    logic [19:0] hold20_sum;

    pipelined_carry_select_addsub #(.DATA_WIDTH(64), .BLOCK_SIZE(8), .BLOCKS_PER_STAGE(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .sum(w_sum), .cout(w_cout), .ovf(w_ovf));

    pipelined_carry_select_addsub #(.DATA_WIDTH(20), .BLOCK_SIZE(8), .BLOCKS_PER_STAGE(2)) u_dut20 (
        .clk(clk), .rst_n(rst_n), .flush(n_flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .cin(n_cin), .sub(n_sub), .out_valid(n_out_valid),
        .out_ready(n_out_ready), .sum(n_sum), .cout(n_cout), .ovf(n_ovf));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
        end
    endtask

    // {ovf, cout, sum} for a w-bit add (a+b+cin) or subtract (a-b).
    function automatic logic [65:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic c, input logic s);
        logic [64:0] m, xe, ye, full;
        logic [63:0] r;
        logic        co, sx, sy, sr, ov;
        m  = (65'd1 << w) - 65'd1;
        xe = {1'b0, x} & m;
        ye = {1'b0, y} & m;
        if (s) begin
            full = xe - ye;
            co   = (xe >= ye);
        end else begin
            full = xe + ye + {64'd0, c};
            co   = 1'(full >> w);
        end
        r  = full[63:0] & m[63:0];
        sx = 1'(xe >> (w - 1));
        sy = 1'(ye >> (w - 1));
        sr = 1'(r >> (w - 1));
        ov = s ? (sx != sy && sr != sx) : (sx == sy && sr != sx);
        return {ov, co, r};
    endfunction

    always @(negedge clk) begin : sb64
        logic [65:0] e;
        if (!rst_n) begin
            q64.delete();
            hold64 = 1'b0;
        end else begin
            if (hold64) begin
                check("w_stall_valid", 64'(w_out_valid), 64'd1);
                check("w_stall_sum", w_sum, hold64_sum);
            end
            if (w_out_valid && w_out_ready && !flush) begin
                if (q64.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL w_extra: got result 0x%h, want none pending", w_sum);
                end else begin
                    e = q64.pop_front();
                    check("w_sum", w_sum, e[63:0]);
                    check("w_cout", 64'(w_cout), 64'(e[64]));
                    check("w_ovf", 64'(w_ovf), 64'(e[65]));
                    seen64.push_back(w_sum);
                end
            end
            if (flush) q64.delete();
            else if (w_in_valid && w_in_ready) q64.push_back(model(64, w_a, w_b, w_cin, w_sub));
            hold64     = w_out_valid && !w_out_ready && !flush;
            hold64_sum = w_sum;
        end
    end

    always @(negedge clk) begin : sb20
        logic [65:0] e;
        if (!rst_n) begin
            q20.delete();
            hold20 = 1'b0;
        end else begin
            if (hold20) begin
                check("n_stall_valid", 64'(n_out_valid), 64'd1);
                check("n_stall_sum", 64'(n_sum), 64'(hold20_sum));
            end
            if (n_out_valid && n_out_ready && !n_flush) begin
                if (q20.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL n_extra: got result 0x%h, want none pending", n_sum);
                end else begin
                    e = q20.pop_front();
                    check("n_sum", 64'(n_sum), e[63:0]);
                    check("n_cout", 64'(n_cout), 64'(e[64]));
                    check("n_ovf", 64'(n_ovf), 64'(e[65]));
                end
            end
            if (n_flush) q20.delete();
            else if (n_in_valid && n_in_ready) q20.push_back(model(20, 64'(n_a), 64'(n_b), n_cin, n_sub));
            hold20     = n_out_valid && !n_out_ready && !n_flush;
            hold20_sum = n_sum;
        end
    end

    task automatic one_beat64(input string nm, input logic [63:0] x, input logic [63:0] y,
                              input logic c, input logic s, input logic [63:0] es,
                              input logic ec, input logic eo);
        @(posedge clk); #1;
        w_in_valid = 1'b1; w_a = x; w_b = y; w_cin = c; w_sub = s; w_out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_in_ready"}, 64'(w_in_ready), 64'd1);
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            check({nm, "_out_valid"}, 64'(w_out_valid), 64'(cyc == 4));
        end
        check({nm, "_sum"}, w_sum, es);
        check({nm, "_cout"}, 64'(w_cout), 64'(ec));
        check({nm, "_ovf"}, 64'(w_ovf), 64'(eo));
    endtask

    task automatic one_beat20(input string nm, input logic [19:0] x, input logic [19:0] y,
                              input logic c, input logic s, input logic [19:0] es,
                              input logic ec, input logic eo);
        @(posedge clk); #1;
        n_in_valid = 1'b1; n_a = x; n_b = y; n_cin = c; n_sub = s; n_out_ready = 1'b1;
        @(negedge clk);
        check({nm, "_in_ready"}, 64'(n_in_ready), 64'd1);
        @(posedge clk); #1;
        n_in_valid = 1'b0;
        for (int cyc = 1; cyc <= 2; cyc++) begin
            @(negedge clk);
            check({nm, "_out_valid"}, 64'(n_out_valid), 64'(cyc == 2));
        end
        check({nm, "_sum"}, 64'(n_sum), 64'(es));
        check({nm, "_cout"}, 64'(n_cout), 64'(ec));
        check({nm, "_ovf"}, 64'(n_ovf), 64'(eo));
    endtask

    task automatic drain64(input string nm);
        int n = 0;
        w_out_ready = 1'b1;
        while ((q64.size() != 0 || w_out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_drained"}, 64'(q64.size()), 64'd0);
    endtask

    task automatic drain20(input string nm);
        int n = 0;
        n_out_ready = 1'b1;
        while ((q20.size() != 0 || n_out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_drained"}, 64'(q20.size()), 64'd0);
    endtask

    initial begin : stim
        int          idx, cyc, stall_acc, sent, r;
        logic        acc, busy;
        rst_n = 1'b1; flush = 1'b0; n_flush = 1'b0;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_sub = 1'b0; w_out_ready = 1'b1;
        n_in_valid = 1'b0; n_a = '0; n_b = '0; n_cin = 1'b0; n_sub = 1'b0; n_out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_w_out_valid", 64'(w_out_valid), 64'd0);
        check("rst_w_sum", w_sum, 64'd0);
        check("rst_w_cout", 64'(w_cout), 64'd0);
        check("rst_w_ovf", 64'(w_ovf), 64'd0);
        check("rst_n_out_valid", 64'(n_out_valid), 64'd0);
        check("rst_n_sum", 64'(n_sum), 64'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        check("rst_w_in_ready", 64'(w_in_ready), 64'd1);
        check("rst_n_in_ready", 64'(n_in_ready), 64'd1);

        one_beat64("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        one_beat64("sub_borrow", 64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        one_beat64("sub_noborrow", 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
        one_beat64("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                   64'h8000_0000_0000_0000, 1'b0, 1'b1);
        one_beat64("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                   64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        one_beat20("odd_wrap", 20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0);
        one_beat20("odd_sub_ovf", 20'h80000, 20'h00001, 1'b0, 1'b1, 20'h7FFFF, 1'b1, 1'b1);

        // Backpressure: ten beats a=i, b=3i, cin=1 with the sink stalled 6 cycles.
        seen64.delete();
        idx = 1; cyc = 0; stall_acc = 0;
        while (idx <= 10 && cyc < 40) begin
            @(posedge clk); #1;
            w_in_valid = 1'b1; w_a = 64'(idx); w_b = 64'(3 * idx); w_cin = 1'b1; w_sub = 1'b0;
            w_out_ready = (cyc >= 6);
            @(negedge clk);
            acc = w_in_ready;
            if (cyc < 6 && acc) stall_acc++;
            if (cyc == 4) check("bp_in_ready_full", 64'(w_in_ready), 64'd0);
            if (acc) idx++;
            cyc++;
        end
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        check("bp_stall_accepts", 64'(stall_acc), 64'd4);
        check("bp_cycles", 64'(cyc), 64'd12);
        drain64("bp");
        check("bp_count", 64'(seen64.size()), 64'd10);
        for (int i = 0; i < 10 && i < seen64.size(); i++)
            check("bp_order", seen64[i], 64'(4 * (i + 1) + 1));

        // Flush with three beats in flight; a beat offered during flush is refused.
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_in_valid = 1'b1; w_a = 64'(100 + i); w_b = 64'd1; w_cin = 1'b0; w_sub = 1'b0;
            @(posedge clk); #1;
        end
        w_in_valid = 1'b0;
        @(posedge clk); #1;
        check("fl_pre_valid", 64'(w_out_valid), 64'd1);
        flush = 1'b1; w_in_valid = 1'b1; w_a = 64'hDEAD; w_b = 64'd0;
        @(negedge clk);
        check("fl_in_ready", 64'(w_in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b1;
        check("fl_out_valid", 64'(w_out_valid), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fl_no_stale", 64'(w_out_valid), 64'd0);
        end

        // Asynchronous reset with three beats in flight.
        @(posedge clk); #1;
        w_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w_in_valid = 1'b1; w_a = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(i); w_b = 64'h20;
            w_cin = 1'b0; w_sub = 1'b0;
            @(posedge clk); #1;
        end
        w_in_valid = 1'b0;
        @(posedge clk); #1;
        check("rs_pre_valid", 64'(w_out_valid), 64'd1);
        check("rs_pre_cout", 64'(w_cout), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_out_valid", 64'(w_out_valid), 64'd0);
        check("rs_sum", w_sum, 64'd0);
        check("rs_cout", 64'(w_cout), 64'd0);
        check("rs_ovf", 64'(w_ovf), 64'd0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        w_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rs_no_partial", 64'(w_out_valid), 64'd0);
        end

        // Random traffic on the 20-bit, two-stage instance.
        sent = 0; cyc = 0; busy = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            if (!busy) begin
                n_in_valid = ($urandom_range(3) != 0);
                r = int'($urandom_range(7));
                n_a = (r == 0) ? 20'hFFFFF : (r == 1) ? 20'h80000 : 20'($urandom);
                n_b = (r == 2) ? 20'hFFFFF : (r == 3) ? 20'h00001 : 20'($urandom);
                n_cin = 1'($urandom_range(1));
                n_sub = 1'($urandom_range(1));
            end
            n_out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (n_in_valid && n_in_ready) begin
                sent++;
                busy = 1'b0;
            end else begin
                busy = n_in_valid;
            end
            cyc++;
        end
        check("rnd_sent", 64'(sent), 64'd1000);
        @(posedge clk); #1;
        n_in_valid = 1'b0;
        drain20("rnd");
        drain64("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
